// File: rtl/riscv_mmio_uart.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, sitting on the riscv core's data bus.
// Also muxes the core's read data between the UART register window and data RAM.
module riscv_mmio_uart #(
  parameter logic [29:0] MMIO_BASE    = 30'h3FFF_FFC0,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] mem_addr,
  input  logic        mem_write,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] ram_read_data,
  output logic [31:0] mem_read_data,
  output logic        tx,
  output logic        tx_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            tx_busy_q, tx_busy_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            enable_q, enable_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];

  logic [29:0] offset;
  logic        hit, wr_txdata, wr_status, wr_ctrl;
  logic        fifo_full, fifo_empty, last_tick, pop, push_ok;
  logic [31:0] status_word;

  // Address decode: the subtraction wraps, so anything below the base lands far above 3.
  assign offset     = mem_addr - MMIO_BASE;
  assign hit        = (offset < 30'd4);
  assign wr_txdata  = mem_write && hit && (offset[1:0] == 2'd0);
  assign wr_status  = mem_write && hit && (offset[1:0] == 2'd1);
  assign wr_ctrl    = mem_write && hit && (offset[1:0] == 2'd2);

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign last_tick  = (timer_q == TW'(CLKS_PER_BIT - 1));

  // Serializer next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (enable_q && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (last_tick) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (last_tick) begin
          timer_d   = '0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (last_tick) begin
          timer_d = '0;
          if (enable_q && !fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered from the next state so the line changes on the same edge as the state.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    tx_busy_d = (state_d != S_IDLE);
  end

  // FIFO bookkeeping and control registers.
  always_comb begin
    push_ok = wr_txdata && (!fifo_full || pop);
    wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (wr_txdata && !push_ok)                 overflow_d = 1'b1;
    else if (wr_status && mem_write_data[3])   overflow_d = 1'b0;
    else                                       overflow_d = overflow_q;
    enable_d = wr_ctrl ? mem_write_data[0] : enable_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together.
    if (!rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      enable_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      enable_q   <= enable_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wptr_q] <= mem_write_data[7:0];
  end

  assign status_word = {24'b0, 4'(count_q), overflow_q, tx_busy_q, fifo_empty, fifo_full};

  always_comb begin
    mem_read_data = ram_read_data;
    if (hit) begin
      case (offset[1:0])
        2'd1:    mem_read_data = status_word;
        2'd2:    mem_read_data = {31'b0, enable_q};
        default: mem_read_data = '0;
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, mem_write_data[31:8]};

endmodule
